vu_vmu_dcachereq_arb: RTL and testbench

Arbiter and sequencer for the vector memory unit's single D$ request port. It shares the port between the load request queue (lrq) and the store request queue (srq). Stores have priority, bounded by a store-run limit so loads cannot starve. Loads are throttled by an outstanding-load credit counter sized to the reorder queue, and every request is driven through a one-entry registered output stage.

---
 rtl/vu_vmu_dcachereq_arb_if.sv | 42 ++++
 rtl/vu_vmu_dcachereq_arb.sv | 135 +++++++++++++
 tb/tb_vu_vmu_dcachereq_arb.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vu_vmu_dcachereq_arb_if.sv
// Request/response bundle between the load/store request queues, the arbiter and the D$ port.
interface vu_vmu_dcachereq_arb_if;
    logic [35:0]  lrq_deq_bits;
    logic         lrq_deq_val;
    logic         lrq_deq_rdy;
    logic [171:0] srq_deq_bits;
    logic         srq_deq_val;
    logic         srq_deq_rdy;
    logic [27:0]  dcachereq_addr;
    logic [11:0]  dcachereq_tag;
    logic [127:0] dcachereq_data;
    logic [15:0]  dcachereq_wmask;
    logic [3:0]   dcachereq_op;
    logic         dcachereq_val;
    logic         dcachereq_rdy;
    logic         dcacheresp_val;
    logic [11:0]  dcacheresp_tag;

    // Arbiter side
    modport master (
        input  lrq_deq_bits, lrq_deq_val,
        output lrq_deq_rdy,
        input  srq_deq_bits, srq_deq_val,
        output srq_deq_rdy,
        output dcachereq_addr, dcachereq_tag, dcachereq_data, dcachereq_wmask,
        output dcachereq_op, dcachereq_val,
        input  dcachereq_rdy,
        input  dcacheresp_val, dcacheresp_tag
    );

    // Queue / D$ side
    modport slave (
        output lrq_deq_bits, lrq_deq_val,
        input  lrq_deq_rdy,
        output srq_deq_bits, srq_deq_val,
        input  srq_deq_rdy,
        input  dcachereq_addr, dcachereq_tag, dcachereq_data, dcachereq_wmask,
        input  dcachereq_op, dcachereq_val,
        output dcachereq_rdy,
        output dcacheresp_val, dcacheresp_tag
    );
endinterface

// File: rtl/vu_vmu_dcachereq_arb.sv
// Shares the single D$ request port between the load and store request queues.
// Stores win unless a waiting load has watched MAX_ST_RUN consecutive store grants;
// loads are limited by an outstanding-load credit count. One registered output stage.
module vu_vmu_dcachereq_arb #(
    parameter int unsigned MAX_ST_RUN = 4,
    parameter int unsigned LD_CREDITS = 256,
    parameter int unsigned CREDIT_W   = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    vu_vmu_dcachereq_arb_if.master dc,
    output logic [CREDIT_W-1:0]    ld_outstanding,
    output logic                   idle
);
    localparam int unsigned         RUN_W      = (MAX_ST_RUN > 0) ? $clog2(MAX_ST_RUN + 1) : 1;
    localparam logic [RUN_W-1:0]    RUN_MAX    = RUN_W'(MAX_ST_RUN);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(LD_CREDITS);
    localparam logic [11:0]         ST_TAG     = 12'h800;
    localparam logic [3:0]          OP_ST      = 4'b0001;
    localparam logic [3:0]          OP_LD      = 4'b0000;

    logic                val_q, val_d;
    logic [27:0]         addr_q, addr_d;
    logic [11:0]         tag_q, tag_d;
    logic [127:0]        data_q, data_d;
    logic [15:0]         wmask_q, wmask_d;
    logic [3:0]          op_q, op_d;
    logic [RUN_W-1:0]    st_run_q, st_run_d;
    logic [CREDIT_W-1:0] ld_cnt_q, ld_cnt_d;

    logic out_free;
    logic ld_elig;
    logic force_ld;
    logic grant_st;
    logic grant_ld;
    logic ld_resp;
    logic unused_resp_tag;

    // Arbitration: eligibility uses the registered credit count only
    assign out_free = ~val_q | dc.dcachereq_rdy;
    assign ld_elig  = dc.lrq_deq_val & (ld_cnt_q < CREDIT_MAX);
    assign force_ld = ld_elig & (st_run_q == RUN_MAX);
    assign grant_st = out_free & dc.srq_deq_val & ~force_ld;
    assign grant_ld = out_free & ld_elig & ~grant_st;
    assign ld_resp  = dc.dcacheresp_val & ~dc.dcacheresp_tag[11];

    assign unused_resp_tag = ^dc.dcacheresp_tag[10:0];

    assign dc.srq_deq_rdy = grant_st;
    assign dc.lrq_deq_rdy = grant_ld;

    assign dc.dcachereq_val   = val_q;
    assign dc.dcachereq_addr  = addr_q;
    assign dc.dcachereq_tag   = tag_q;
    assign dc.dcachereq_data  = data_q;
    assign dc.dcachereq_wmask = wmask_q;
    assign dc.dcachereq_op    = op_q;
    assign ld_outstanding     = ld_cnt_q;
    assign idle               = ~val_q & (ld_cnt_q == '0);

    // Next-state for the output stage, store-run counter and load credit counter
    always_comb begin
        val_d    = val_q;
        addr_d   = addr_q;
        tag_d    = tag_q;
        data_d   = data_q;
        wmask_d  = wmask_q;
        op_d     = op_q;
        st_run_d = st_run_q;
        ld_cnt_d = ld_cnt_q;

        if (grant_st) begin
            val_d   = 1'b1;
            addr_d  = dc.srq_deq_bits[171:144];
            tag_d   = ST_TAG;
            data_d  = dc.srq_deq_bits[127:0];
            wmask_d = dc.srq_deq_bits[143:128];
            op_d    = OP_ST;
        end else if (grant_ld) begin
            val_d   = 1'b1;
            addr_d  = dc.lrq_deq_bits[35:8];
            tag_d   = {4'd0, dc.lrq_deq_bits[7:0]};
            data_d  = '0;
            wmask_d = '0;
            op_d    = OP_LD;
        end else if (dc.dcachereq_rdy) begin
            val_d = 1'b0;
        end

        // The run only counts stores that actually made a load wait
        if (!ld_elig || grant_ld) begin
            st_run_d = '0;
        end else if (grant_st && (st_run_q != RUN_MAX)) begin
            st_run_d = st_run_q + RUN_W'(1);
        end

        // Loads are counted at grant; a grant and a response together cancel
        if (grant_ld && !ld_resp) begin
            ld_cnt_d = ld_cnt_q + CREDIT_W'(1);
        end else if (!grant_ld && ld_resp && (ld_cnt_q != '0)) begin
            ld_cnt_d = ld_cnt_q - CREDIT_W'(1);
        end
    end

    // State registers with synchronous reset; a held request is dropped on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            val_q    <= 1'b0;
            addr_q   <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            wmask_q  <= '0;
            op_q     <= '0;
            st_run_q <= '0;
            ld_cnt_q <= '0;
        end else begin
            val_q    <= val_d;
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            wmask_q  <= wmask_d;
            op_q     <= op_d;
            st_run_q <= st_run_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end

    // Flags a load response arriving with no load outstanding
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(ld_resp && !grant_ld && (ld_cnt_q == '0)))
                else $error("load response with no outstanding load");
        end
    end
endmodule

// File: tb/tb_vu_vmu_dcachereq_arb.sv
// Directed bench for the D$ request arbiter with a cycle-level reference model.
module tb_vu_vmu_dcachereq_arb;
    localparam int unsigned MAX_RUN = 4;
    localparam int unsigned CRED    = 8;
    localparam int unsigned CW      = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] ld_outstanding;
    logic          idle;

    vu_vmu_dcachereq_arb_if bus();

    vu_vmu_dcachereq_arb #(
        .MAX_ST_RUN(MAX_RUN),
        .LD_CREDITS(CRED),
        .CREDIT_W  (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dc            (bus),
        .ld_outstanding(ld_outstanding),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: expected output stage, outstanding loads, consecutive stores seen by a waiting load
    bit           m_known = 1'b0;
    bit           m_val;
    logic [27:0]  m_addr;
    logic [11:0]  m_tag;
    logic [127:0] m_data;
    logic [15:0]  m_wmask;
    logic [3:0]   m_op;
    int           m_out;
    int           m_streak;
    bit           free, ld_ok, gs, gl;
    bit           rec = 1'b0;
    string        order = "";

    // Mid-cycle: check DUT against model, then advance model to the next edge
    always @(negedge clk) begin
        if (m_known) begin
            chk("req_val", 128'(bus.dcachereq_val), 128'(m_val));
            if (m_val) begin
                chk("req_addr",  128'(bus.dcachereq_addr),  128'(m_addr));
                chk("req_tag",   128'(bus.dcachereq_tag),   128'(m_tag));
                chk("req_data",  bus.dcachereq_data,        m_data);
                chk("req_wmask", 128'(bus.dcachereq_wmask), 128'(m_wmask));
                chk("req_op",    128'(bus.dcachereq_op),    128'(m_op));
            end
            chk("ld_outstanding", 128'(ld_outstanding), 128'(m_out));
            chk("idle", 128'(idle), 128'(!m_val && (m_out == 0)));
        end
        if (reset) begin
            m_known  = 1'b1;
            m_val    = 1'b0;
            m_out    = 0;
            m_streak = 0;
        end else if (m_known) begin
            free  = !m_val || bus.dcachereq_rdy;
            ld_ok = bus.lrq_deq_val && (m_out < int'(CRED));
            gs    = free && bus.srq_deq_val && !(ld_ok && (m_streak >= int'(MAX_RUN)));
            gl    = free && ld_ok && !gs;
            chk("srq_deq_rdy", 128'(bus.srq_deq_rdy), 128'(gs));
            chk("lrq_deq_rdy", 128'(bus.lrq_deq_rdy), 128'(gl));
            if (rec) order = {order, bus.srq_deq_rdy ? "S" : (bus.lrq_deq_rdy ? "L" : "-")};
            if (gs) begin
                m_val   = 1'b1;
                m_addr  = bus.srq_deq_bits[171:144];
                m_wmask = bus.srq_deq_bits[143:128];
                m_data  = bus.srq_deq_bits[127:0];
                m_tag   = 12'h800;
                m_op    = 4'b0001;
            end else if (gl) begin
                m_val   = 1'b1;
                m_addr  = bus.lrq_deq_bits[35:8];
                m_tag   = {4'd0, bus.lrq_deq_bits[7:0]};
                m_data  = '0;
                m_wmask = '0;
                m_op    = 4'b0000;
            end else if (bus.dcachereq_rdy) begin
                m_val = 1'b0;
            end
            if (!ld_ok || gl) m_streak = 0;
            else if (gs && (m_streak < int'(MAX_RUN))) m_streak++;
            if (gl) m_out++;
            if (bus.dcacheresp_val && !bus.dcacheresp_tag[11] && (m_out > 0)) m_out--;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    localparam logic [171:0] ST_A = {28'hABCDE01, 16'hF0F0, 128'h0123456789ABCDEF_FEDCBA9876543210};
    localparam logic [171:0] ST_B = {28'h5555AAA, 16'h00FF, 128'hDEADBEEF_CAFEF00D_00000000_12345678};

    initial begin
        reset                 = 1'b1;
        bus.lrq_deq_bits      = '0;
        bus.lrq_deq_val       = 1'b0;
        bus.srq_deq_bits      = '0;
        bus.srq_deq_val       = 1'b0;
        bus.dcachereq_rdy     = 1'b1;
        bus.dcacheresp_val    = 1'b0;
        bus.dcacheresp_tag    = '0;
        tick;
        tick;
        chk("reset_val",  128'(bus.dcachereq_val), 128'(0));
        chk("reset_out",  128'(ld_outstanding),    128'(0));
        chk("reset_idle", 128'(idle),              128'(1));
        reset = 1'b0;

        // Single load, one-cycle latency
        bus.lrq_deq_val  = 1'b1;
        bus.lrq_deq_bits = {28'h0000123, 8'h05};
        tick;
        bus.lrq_deq_val = 1'b0;
        chk("ld_val",   128'(bus.dcachereq_val),   128'(1));
        chk("ld_addr",  128'(bus.dcachereq_addr),  128'(28'h0000123));
        chk("ld_tag",   128'(bus.dcachereq_tag),   128'(12'h005));
        chk("ld_op",    128'(bus.dcachereq_op),    128'(0));
        chk("ld_wmask", 128'(bus.dcachereq_wmask), 128'(0));
        chk("ld_out1",  128'(ld_outstanding),      128'(1));
        bus.dcacheresp_val = 1'b1;
        bus.dcacheresp_tag = 12'h005;
        tick;
        bus.dcacheresp_val = 1'b0;
        chk("ld_out0", 128'(ld_outstanding), 128'(0));

        // Store/load contention, store-run limit
        bus.srq_deq_bits = ST_A;
        bus.srq_deq_val  = 1'b1;
        bus.lrq_deq_bits = {28'h0000456, 8'h2A};
        bus.lrq_deq_val  = 1'b1;
        order = "";
        rec   = 1'b1;
        tick;
        chk("st_tag",   128'(bus.dcachereq_tag),   128'(12'h800));
        chk("st_op",    128'(bus.dcachereq_op),    128'(4'b0001));
        chk("st_addr",  128'(bus.dcachereq_addr),  128'(28'hABCDE01));
        chk("st_wmask", 128'(bus.dcachereq_wmask), 128'(16'hF0F0));
        chk("st_data",  bus.dcachereq_data,        128'h0123456789ABCDEF_FEDCBA9876543210);
        repeat (9) tick;
        rec             = 1'b0;
        bus.srq_deq_val = 1'b0;
        bus.lrq_deq_val = 1'b0;
        checks++;
        if (order != "SSSSLSSSSL") begin
            errors++;
            $display("FAIL grant_order actual=%s required=SSSSLSSSSL", order);
        end
        chk("run_out", 128'(ld_outstanding), 128'(2));
        bus.dcacheresp_val = 1'b1;
        bus.dcacheresp_tag = 12'h02A;
        repeat (2) tick;
        bus.dcacheresp_val = 1'b0;

        // Back-pressure: hold for 5 cycles, then release with a same-cycle grant
        bus.lrq_deq_val  = 1'b1;
        bus.lrq_deq_bits = {28'h0000777, 8'h11};
        tick;
        bus.dcachereq_rdy = 1'b0;
        bus.lrq_deq_bits  = {28'h0000888, 8'h12};
        bus.srq_deq_bits  = ST_B;
        bus.srq_deq_val   = 1'b1;
        repeat (5) tick;
        chk("stall_val",  128'(bus.dcachereq_val),  128'(1));
        chk("stall_addr", 128'(bus.dcachereq_addr), 128'(28'h0000777));
        chk("stall_srdy", 128'(bus.srq_deq_rdy),    128'(0));
        chk("stall_lrdy", 128'(bus.lrq_deq_rdy),    128'(0));
        bus.dcachereq_rdy = 1'b1;
        #1;
        chk("release_srdy", 128'(bus.srq_deq_rdy), 128'(1));
        tick;
        chk("nobubble_val",  128'(bus.dcachereq_val),  128'(1));
        chk("nobubble_addr", 128'(bus.dcachereq_addr), 128'(28'h5555AAA));
        bus.srq_deq_val = 1'b0;
        bus.lrq_deq_val = 1'b0;
        tick;
        chk("drain_val", 128'(bus.dcachereq_val), 128'(0));
        bus.dcacheresp_val = 1'b1;
        bus.dcacheresp_tag = 12'h011;
        tick;
        bus.dcacheresp_val = 1'b0;

        // Credit exhaustion
        bus.lrq_deq_val  = 1'b1;
        bus.lrq_deq_bits = {28'h0000100, 8'h20};
        repeat (8) tick;
        chk("full_out",  128'(ld_outstanding),  128'(8));
        chk("full_lrdy", 128'(bus.lrq_deq_rdy), 128'(0));
        tick;
        chk("full_out2", 128'(ld_outstanding), 128'(8));
        bus.dcacheresp_val = 1'b1;
        bus.dcacheresp_tag = 12'h003;
        #1;
        chk("full_resp_lrdy", 128'(bus.lrq_deq_rdy), 128'(0));
        tick;
        bus.dcacheresp_val = 1'b0;
        #1;
        chk("credit_out7", 128'(ld_outstanding),  128'(7));
        chk("credit_lrdy", 128'(bus.lrq_deq_rdy), 128'(1));
        tick;
        chk("credit_out8", 128'(ld_outstanding), 128'(8));

        // Simultaneous grant and response; store acks ignored
        bus.lrq_deq_val    = 1'b0;
        bus.dcacheresp_val = 1'b1;
        bus.dcacheresp_tag = 12'h003;
        tick;
        bus.lrq_deq_val = 1'b1;
        tick;
        chk("same_cycle_out", 128'(ld_outstanding), 128'(7));
        bus.lrq_deq_val    = 1'b0;
        bus.dcacheresp_tag = 12'h803;
        tick;
        chk("st_ack_out", 128'(ld_outstanding), 128'(7));

        // Reset with a held request and loads outstanding
        bus.dcacheresp_tag = 12'h003;
        repeat (5) tick;
        bus.dcacheresp_val = 1'b0;
        bus.dcachereq_rdy  = 1'b0;
        bus.lrq_deq_val    = 1'b1;
        tick;
        bus.lrq_deq_val = 1'b0;
        chk("pre_reset_val", 128'(bus.dcachereq_val), 128'(1));
        chk("pre_reset_out", 128'(ld_outstanding),    128'(3));
        reset = 1'b1;
        tick;
        chk("mid_reset_val",  128'(bus.dcachereq_val), 128'(0));
        chk("mid_reset_out",  128'(ld_outstanding),    128'(0));
        chk("mid_reset_idle", 128'(idle),              128'(1));
        reset             = 1'b0;
        bus.dcachereq_rdy = 1'b1;
        repeat (2) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
